updown_counter_param: RTL

Parametrised up/down counter that generalises the team's fixed 4-bit down counter. It adds configurable width and modulus, a runtime direction select, synchronous load and clear, a programmable step prescaler, and wrap or saturate mode. A terminal-count pulse and status flags let it act as a timebase or event counter inside larger designs.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/step_prescaler.sv | 36 +++
 rtl/updown_counter_param.sv | 113 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the parametrised up/down counter and its prescaler.
package counter_pkg;

  // Direction encoding on the up input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Boundary behaviour selected by the SATURATE parameter.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // What a counting step does to the value, resolved from direction and boundary.
  typedef enum logic [1:0] {
    ACT_INC  = 2'd0,
    ACT_DEC  = 2'd1,
    ACT_WRAP = 2'd2,
    ACT_HOLD = 2'd3
  } step_act_e;

endpackage

// File: rtl/step_prescaler.sv
// Enable-gated prescaler: issues one step pulse every div+1 enabled cycles.
module step_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [PRE_W-1:0] div,
  output logic             step
);

  logic [PRE_W-1:0] pre;
  logic             pre_hit;

  // >= rather than == so that lowering div below the running count fires
  // on the very next enabled cycle instead of running round the full range.
  assign pre_hit = (pre >= div);
  assign step    = en && !clear && pre_hit;

  // Prescale count: reset by clear, advanced only on enabled cycles, held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (clear) begin
      pre <= '0;
    end else if (en) begin
      if (pre_hit) begin
        pre <= '0;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with clear, clamped load, prescaled stepping,
// wrap or saturate boundary mode, terminal-count pulse and status flags.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter int               SATURATE = MODE_WRAP,
  parameter int               PRE_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PRE_W-1:0] div,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             zero,
  output logic             sat
);

  localparam bit SAT_MODE = (SATURATE == MODE_SAT);

  logic             step;
  logic [WIDTH-1:0] terminal;
  logic             at_term;
  step_act_e        act;
  logic [WIDTH-1:0] out_nxt;
  logic             tc_nxt;

  // Loaded values above the modulus are pulled down to MAX so out never leaves 0..MAX.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX) ? MAX : v;
  endfunction

  // Decide what a step does given the direction and whether out sits on the boundary.
  function automatic step_act_e step_action(input logic dir, input logic on_term);
    step_act_e a;
    if (!on_term) begin
      a = (dir == DIR_UP) ? ACT_INC : ACT_DEC;
    end else if (SAT_MODE) begin
      a = ACT_HOLD;
    end else begin
      a = ACT_WRAP;
    end
    return a;
  endfunction

  // Apply a step action; wrapping lands on the opposite boundary of the direction.
  function automatic logic [WIDTH-1:0] apply_step(input logic [WIDTH-1:0] cur,
                                                  input logic dir,
                                                  input step_act_e a);
    logic [WIDTH-1:0] r;
    case (a)
      ACT_INC:  r = cur + 1'b1;
      ACT_DEC:  r = cur - 1'b1;
      ACT_WRAP: r = (dir == DIR_UP) ? '0 : MAX;
      default:  r = cur;
    endcase
    return r;
  endfunction

  // Clear and load both restart the prescale interval.
  step_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (clr | load),
    .div   (div),
    .step  (step)
  );

  // Boundary for the current direction; up is sampled live so a flip costs no latency.
  always_comb begin
    terminal = (up == DIR_UP) ? MAX : '0;
    at_term  = (out == terminal);
    act      = step_action(up, at_term);
  end

  // Next count and terminal-count pulse, clear over load over stepping.
  always_comb begin
    out_nxt = out;
    tc_nxt  = 1'b0;
    if (clr) begin
      out_nxt = '0;
    end else if (load) begin
      out_nxt = clamp_load(load_val);
    end else if (step) begin
      out_nxt = apply_step(out, up, act);
      tc_nxt  = at_term;
    end
  end

  // Count and tc registers; tc lines up with the out value produced by the boundary step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
      tc  <= 1'b0;
    end else begin
      out <= out_nxt;
      tc  <= tc_nxt;
    end
  end

  assign zero = (out == '0);
  assign sat  = SAT_MODE && at_term;

endmodule
